// File: rtl/rr_pkg.sv
// Shared encodings and field positions for the register-read stage.
package rr_pkg;

   localparam logic [1:0] FMT_R    = 2'b11;
   localparam logic [1:0] FMT_I    = 2'b10;
   localparam logic [1:0] FMT_J    = 2'b01;
   localparam logic [1:0] FMT_NONE = 2'b00;

   // Field LSB positions inside the instruction word
   localparam int FMT_LSB = 0;
   localparam int RA_LSB  = 13;
   localparam int RB_LSB  = 10;
   localparam int RD_LSB  = 7;
   localparam int IMM_LSB = 7;

   localparam int IMM_I_W = 6;
   localparam int IMM_J_W = 9;

endpackage

// File: rtl/rr_fwd_mux.sv
// Priority forwarding mux: lowest-index matching source wins, else RF data.
module rr_fwd_mux #(
   parameter int AW      = 3,
   parameter int DATA_W  = 16,
   parameter int NUM_FWD = 2
) (
   input  logic [AW-1:0]             i_addr,
   input  logic [DATA_W-1:0]         i_rf_data,
   input  logic [NUM_FWD-1:0]        i_fwd_valid,
   input  logic [NUM_FWD*AW-1:0]     i_fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
   output logic [DATA_W-1:0]         o_data
);

   // Walk from oldest to youngest so the lowest index overwrites last
   always_comb begin
      o_data = i_rf_data;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (i_fwd_valid[i] && (i_fwd_addr[i*AW +: AW] == i_addr))
            o_data = i_fwd_data[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: decode, operand read with forwarding, load-use bubble.
// Optional RR_PERF_CNT_EN adds saturating hazard/stall counters.
module reg_read_stage
   import rr_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int INSTR_W = 16,
   parameter int AW      = 3,
   parameter int PC_W    = 16,
   parameter int NUM_FWD = 2
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_W-1:0]        in_instr,
   input  logic [PC_W-1:0]           in_pc,
   output logic [AW-1:0]             rf_raddr_a,
   output logic [AW-1:0]             rf_raddr_b,
   input  logic [DATA_W-1:0]         rf_rdata_a,
   input  logic [DATA_W-1:0]         rf_rdata_b,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD*AW-1:0]     fwd_addr,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   input  logic                      ex_load_valid,
   input  logic [AW-1:0]             ex_load_dst,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                out_fmt,
   output logic [DATA_W-1:0]         out_opa,
   output logic [DATA_W-1:0]         out_opb,
   output logic [DATA_W-1:0]         out_imm,
   output logic [AW-1:0]             out_dst,
   output logic [PC_W-1:0]           out_pc
`ifdef RR_PERF_CNT_EN
  ,output logic [31:0]               perf_hazard_cnt,
   output logic [31:0]               perf_stall_cnt
`endif
);

   logic [1:0]         w_fmt;
   logic [AW-1:0]      w_ra, w_rb, w_rd;
   logic [IMM_I_W-1:0] w_imm6;
   logic [IMM_J_W-1:0] w_imm9;
   logic [DATA_W-1:0]  w_val_a, w_val_b;
   logic [DATA_W-1:0]  w_opa, w_opb, w_imm;
   logic [AW-1:0]      w_dst;
   logic               w_hazard, w_advance, w_accept;
   logic               w_unused_instr;

   logic               r_out_valid;
   logic [1:0]         r_fmt;
   logic [DATA_W-1:0]  r_opa, r_opb, r_imm;
   logic [AW-1:0]      r_dst;
   logic [PC_W-1:0]    r_pc;

   assign w_fmt  = in_instr[FMT_LSB +: 2];
   assign w_ra   = in_instr[RA_LSB +: AW];
   assign w_rb   = in_instr[RB_LSB +: AW];
   assign w_rd   = in_instr[RD_LSB +: AW];
   assign w_imm6 = in_instr[IMM_LSB +: IMM_I_W];
   assign w_imm9 = in_instr[IMM_LSB +: IMM_J_W];
   assign w_unused_instr = ^in_instr;

   // Read ports follow the raw fields regardless of in_valid
   assign rf_raddr_a = w_ra;
   assign rf_raddr_b = w_rb;

   rr_fwd_mux #(.AW(AW), .DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_a (
      .i_addr      (w_ra),
      .i_rf_data   (rf_rdata_a),
      .i_fwd_valid (fwd_valid),
      .i_fwd_addr  (fwd_addr),
      .i_fwd_data  (fwd_data),
      .o_data      (w_val_a)
   );

   rr_fwd_mux #(.AW(AW), .DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd_b (
      .i_addr      (w_rb),
      .i_rf_data   (rf_rdata_b),
      .i_fwd_valid (fwd_valid),
      .i_fwd_addr  (fwd_addr),
      .i_fwd_data  (fwd_data),
      .o_data      (w_val_b)
   );

   always_comb begin
      w_opa = '0;
      w_opb = '0;
      w_imm = '0;
      w_dst = '0;
      case (w_fmt)
         FMT_R: begin
            w_opa = w_val_a;
            w_opb = w_val_b;
            w_dst = w_rd;
         end
         FMT_I: begin
            w_opa = w_val_a;
            w_imm = DATA_W'(w_imm6);
            w_dst = w_rb;
         end
         FMT_J:   w_imm = DATA_W'(w_imm9);
         default: ;
      endcase
   end

   // Only operands actually read from the RF can collide with a pending load
   always_comb begin
      w_hazard = 1'b0;
      if (in_valid && ex_load_valid) begin
         case (w_fmt)
            FMT_R:   w_hazard = (w_ra == ex_load_dst) || (w_rb == ex_load_dst);
            FMT_I:   w_hazard = (w_ra == ex_load_dst);
            default: w_hazard = 1'b0;
         endcase
      end
   end

   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance && !w_hazard;
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_fmt       <= '0;
         r_opa       <= '0;
         r_opb       <= '0;
         r_imm       <= '0;
         r_dst       <= '0;
         r_pc        <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= w_accept;
         if (w_accept) begin
            r_fmt <= w_fmt;
            r_opa <= w_opa;
            r_opb <= w_opb;
            r_imm <= w_imm;
            r_dst <= w_dst;
            r_pc  <= in_pc;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_fmt   = r_fmt;
   assign out_opa   = r_opa;
   assign out_opb   = r_opb;
   assign out_imm   = r_imm;
   assign out_dst   = r_dst;
   assign out_pc    = r_pc;

`ifdef RR_PERF_CNT_EN
   // Saturating counters; flush deliberately leaves them untouched
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perf_hazard_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (w_hazard && (perf_hazard_cnt != 32'hFFFF_FFFF))
            perf_hazard_cnt <= perf_hazard_cnt + 32'd1;
         if (r_out_valid && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus randomized
// traffic against a transaction-level model. Honors RR_PERF_CNT_EN.
module tb_reg_read_stage;

   localparam int DATA_W = 16, INSTR_W = 16, AW = 3, PC_W = 16, NUM_FWD = 2;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [15:0] opa;
      logic [15:0] opb;
      logic [15:0] imm;
      logic [2:0]  dst;
      logic [15:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic resetn, flush, in_valid, in_ready, ex_load_valid, out_valid, out_ready;
   logic [INSTR_W-1:0]        in_instr;
   logic [PC_W-1:0]           in_pc;
   logic [AW-1:0]             rf_raddr_a, rf_raddr_b, ex_load_dst, out_dst;
   logic [DATA_W-1:0]         rf_rdata_a, rf_rdata_b, out_opa, out_opb, out_imm;
   logic [NUM_FWD-1:0]        fwd_valid;
   logic [NUM_FWD*AW-1:0]     fwd_addr;
   logic [NUM_FWD*DATA_W-1:0] fwd_data;
   logic [1:0]                out_fmt;
   logic [PC_W-1:0]           out_pc;
`ifdef RR_PERF_CNT_EN
   logic [31:0] perf_hazard_cnt, perf_stall_cnt;
`endif

   logic [15:0] rf [8];
   exp_t obs;
   int n_vec = 0;
   int n_err = 0;

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];
   assign obs = {out_fmt, out_opa, out_opb, out_imm, out_dst, out_pc};

   always #5 clk = ~clk;

   reg_read_stage #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .AW(AW), .PC_W(PC_W),
                    .NUM_FWD(NUM_FWD)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .ex_load_valid(ex_load_valid), .ex_load_dst(ex_load_dst),
      .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
      .out_opa(out_opa), .out_opb(out_opb), .out_imm(out_imm),
      .out_dst(out_dst), .out_pc(out_pc)
`ifdef RR_PERF_CNT_EN
     ,.perf_hazard_cnt(perf_hazard_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   function automatic logic [15:0] mk_r(input logic [2:0] ra, rb, rd);
      return {ra, rb, rd, 5'b0, 2'b11};
   endfunction
   function automatic logic [15:0] mk_i(input logic [2:0] ra, input logic [5:0] imm6);
      return {ra, imm6, 5'b0, 2'b10};
   endfunction
   function automatic logic [15:0] mk_j(input logic [8:0] imm9);
      return {imm9, 5'b0, 2'b01};
   endfunction

   // Reference: operand value seen by the instruction, youngest forward first
   function automatic logic [15:0] val(input logic [2:0] r);
      for (int i = 0; i < NUM_FWD; i++)
         if (fwd_valid[i] && fwd_addr[i*AW +: AW] == r) return fwd_data[i*DATA_W +: DATA_W];
      return rf[r];
   endfunction

   function automatic exp_t model();
      exp_t e;
      logic [2:0] ra, rb, rd;
      ra = in_instr[15:13]; rb = in_instr[12:10]; rd = in_instr[9:7];
      e = '0;
      e.fmt = in_instr[1:0];
      e.pc  = in_pc;
      case (in_instr[1:0])
         2'b11: begin e.opa = val(ra); e.opb = val(rb); e.dst = rd; end
         2'b10: begin e.opa = val(ra); e.imm = {10'b0, in_instr[12:7]}; e.dst = rb; end
         2'b01: e.imm = {7'b0, in_instr[15:7]};
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic model_hazard();
      logic [2:0] ra, rb;
      ra = in_instr[15:13]; rb = in_instr[12:10];
      if (!(in_valid && ex_load_valid)) return 1'b0;
      if (in_instr[1:0] == 2'b11) return (ra == ex_load_dst) || (rb == ex_load_dst);
      if (in_instr[1:0] == 2'b10) return ra == ex_load_dst;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; out_ready = 1; flush = 0; ex_load_valid = 0; fwd_valid = '0;
      tick();
   endtask

   task automatic test_reset();
      resetn = 0; flush = 0; in_valid = 0; out_ready = 1; ex_load_valid = 0;
      ex_load_dst = '0; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
      in_instr = '0; in_pc = '0;
      for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
      tick(); tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_vec++;
      if (obs !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", obs); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
      resetn = 1;
      tick();
   endtask

   task automatic test_r_format();
      exp_t e;
      idle();
      rf[2] = 16'h1234; rf[5] = 16'h00FF;
      in_instr = mk_r(3'd2, 3'd5, 3'd3); in_pc = 16'h0100; in_valid = 1;
      #1;
      n_vec++;
      if (rf_raddr_a !== 3'd2 || rf_raddr_b !== 3'd5) begin
         n_err++; $display("FAIL r_raddr got %0d/%0d want 2/5", rf_raddr_a, rf_raddr_b);
      end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL r_ready got %b want 1", in_ready); end
      e = '{fmt: 2'b11, opa: 16'h1234, opb: 16'h00FF, imm: 16'h0, dst: 3'd3, pc: 16'h0100};
      tick();
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_err++; $display("FAIL r_out got v%b %h want v1 %h", out_valid, obs, e);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL r_drain got %b want 0", out_valid); end
   endtask

   task automatic test_i_fwd();
      exp_t e;
      idle();
      rf[1] = 16'h0007;
      in_instr = mk_i(3'd1, 6'h2A); in_pc = 16'h0102; in_valid = 1;
      fwd_valid = 2'b11; fwd_addr = {3'd1, 3'd1}; fwd_data = {16'hBBBB, 16'hAAAA};
      e = '{fmt: 2'b10, opa: 16'hAAAA, opb: 16'h0, imm: 16'h002A, dst: 3'd5, pc: 16'h0102};
      tick();
      in_valid = 0; fwd_valid = '0;
      n_vec++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_err++; $display("FAIL i_fwd got v%b %h want v1 %h", out_valid, obs, e);
      end
   endtask

   task automatic test_j_format();
      exp_t e;
      idle();
      in_instr = mk_j(9'h1FF); in_pc = 16'h0104; in_valid = 1;
      e = '{fmt: 2'b01, opa: 16'h0, opb: 16'h0, imm: 16'h01FF, dst: 3'd0, pc: 16'h0104};
      tick();
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_err++; $display("FAIL j_out got v%b %h want v1 %h", out_valid, obs, e);
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      idle();
      ex_load_valid = 1; ex_load_dst = 3'd4;
      in_instr = mk_r(3'd1, 3'd4, 3'd2); in_pc = 16'h0106; in_valid = 1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready got %b want 0", in_ready); end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %b want 0", out_valid); end
      ex_load_valid = 0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release got %b want 1", in_ready); end
      e = '{fmt: 2'b11, opa: rf[1], opb: rf[4], imm: 16'h0, dst: 3'd2, pc: 16'h0106};
      tick();
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1'b1 || obs !== e) begin
         n_err++; $display("FAIL lu_accept got v%b %h want v1 %h", out_valid, obs, e);
      end
   endtask

   task automatic test_back_to_back();
      exp_t ea, eb, ec;
      idle();
      in_valid = 1;
      in_instr = mk_r(3'd6, 3'd7, 3'd1); in_pc = 16'h0200; #1; ea = model();
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || obs !== ea) begin
         n_err++; $display("FAIL b2b_a got v%b %h want v1 %h", out_valid, obs, ea);
      end
      in_instr = mk_i(3'd3, 6'h15); in_pc = 16'h0202; #1; eb = model();
      tick();
      out_ready = 0;
      in_instr = mk_j(9'h0A5); in_pc = 16'h0204; #1; ec = model();
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready%0d got %b want 0", k, in_ready); end
         n_vec++;
         if (out_valid !== 1'b1 || obs !== eb) begin
            n_err++; $display("FAIL b2b_hold%0d got v%b %h want v1 %h", k, out_valid, obs, eb);
         end
         tick();
      end
      out_ready = 1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_resume got %b want 1", in_ready); end
      tick();
      in_valid = 0;
      n_vec++;
      if (out_valid !== 1'b1 || obs !== ec) begin
         n_err++; $display("FAIL b2b_c got v%b %h want v1 %h", out_valid, obs, ec);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_dup got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      idle();
      in_instr = mk_r(3'd1, 3'd2, 3'd3); in_pc = 16'h0300; in_valid = 1;
      tick();
      out_ready = 0; in_instr = mk_i(3'd2, 6'h11); in_pc = 16'h0302; flush = 1;
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill got %b want 0", out_valid); end
      flush = 0; in_valid = 0; out_ready = 1;
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      logic m_valid;
      exp_t m_out, e_new;
      logic hz, adv, exp_ready;
      idle();
      m_valid = 0; m_out = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
         in_instr      = 16'($urandom);
         in_pc         = 16'($urandom);
         in_valid      = ($urandom_range(3) != 0);
         out_ready     = ($urandom_range(2) != 0);
         flush         = ($urandom_range(15) == 0);
         ex_load_valid = ($urandom_range(3) == 0);
         ex_load_dst   = 3'($urandom);
         fwd_valid     = 2'($urandom);
         fwd_addr      = 6'($urandom);
         fwd_data      = 32'($urandom);
         #1;
         hz = model_hazard();
         adv = !m_valid || out_ready;
         exp_ready = adv && !hz;
         e_new = model();
         n_vec++;
         if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL rand_ready cyc %0d got %b want %b", c, in_ready, exp_ready);
         end
         tick();
         if (flush) m_valid = 0;
         else if (adv) begin
            m_valid = in_valid && exp_ready;
            if (m_valid) m_out = e_new;
         end
         n_vec++;
         if (out_valid !== m_valid || (m_valid && obs !== m_out)) begin
            n_err++; $display("FAIL rand_out cyc %0d got v%b %h want v%b %h", c, out_valid, obs, m_valid, m_out);
         end
      end
      idle();
   endtask

   task automatic test_reset_midstream();
      idle();
      in_instr = mk_r(3'd5, 3'd6, 3'd7); in_pc = 16'hBEEF; in_valid = 1; rf[5] = 16'hFFFF;
      tick();
      out_ready = 0; flush = 1; resetn = 0;
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || obs !== '0) begin
         n_err++; $display("FAIL rst_mid got v%b %h want v0 0", out_valid, obs);
      end
      in_valid = 0; flush = 0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
      resetn = 1;
      tick();
   endtask

`ifdef RR_PERF_CNT_EN
   task automatic test_perf();
      resetn = 0; idle(); resetn = 1;
      n_vec++;
      if (perf_hazard_cnt !== 0 || perf_stall_cnt !== 0) begin
         n_err++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_hazard_cnt, perf_stall_cnt);
      end
      in_instr = mk_r(3'd4, 3'd1, 3'd2); in_valid = 1; ex_load_valid = 1; ex_load_dst = 3'd4;
      repeat (3) tick();
      ex_load_valid = 0;
      tick();
      in_valid = 0; out_ready = 0;
      repeat (2) tick();
      flush = 1;
      tick();
      flush = 0; out_ready = 1;
      tick();
      n_vec++;
      if (perf_hazard_cnt !== 32'd3 || perf_stall_cnt !== 32'd3) begin
         n_err++; $display("FAIL perf_count got %0d/%0d want 3/3", perf_hazard_cnt, perf_stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_r_format();
      test_i_fwd();
      test_j_format();
      test_load_use();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_midstream();
`ifdef RR_PERF_CNT_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Parametrised register-read pipeline stage of the IITB RISC core, between decode and execute.
- Decodes the source fields and immediate of one instruction per cycle and reads two operands from the register file.
- Resolves RAW hazards by forwarding from later stages, and inserts a bubble on a load-use hazard.
- Holds results in an output pipeline register with a valid/ready handshake, stall and flush.

Parameters:
- DATA_W, 16: operand/register width.
- INSTR_W, 16: instruction width; must be ≥16.
- AW, 3: register address width (2**AW registers).
- PC_W, 16: PC width.
- NUM_FWD, 2: number of forwarding sources; index 0 is the youngest stage.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset. Synchronous, active-low.
- flush  in  1  synchronous kill of the held and incoming instruction.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  INSTR_W  instruction.
- in_pc  in  PC_W  instruction PC.
- rf_raddr_a, rf_raddr_b  out  AW each  register-file read addresses (combinational).
- rf_rdata_a, rf_rdata_b  in  DATA_W each  register-file read data, same cycle.
- fwd_valid  in  NUM_FWD  forwarding source carries a register write.
- fwd_addr  in  NUM_FWD*AW  packed destination addresses.
- fwd_data  in  NUM_FWD*DATA_W  packed write data.
- ex_load_valid  in  1  execute stage holds a load.
- ex_load_dst  in  AW  destination of that load.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  execute accepts.
- out_fmt  out  2  format: 11 R, 10 I, 01 J, 00 none.
- out_opa, out_opb  out  DATA_W  operands.
- out_imm  out  DATA_W  extended immediate.
- out_dst  out  AW  destination field.
- out_pc  out  PC_W  PC.

Behaviour:
- Fields:
  - fmt = instr[1:0]; ra = instr[15:13]; rb = instr[12:10]; rd = instr[9:7].
  - I-format imm6 = instr[12:7]; J-format imm9 = instr[15:7].
- rf_raddr_a = ra and rf_raddr_b = rb always; they are not gated by in_valid.
- Operand source per format:
  - R: opa = val(ra), opb = val(rb), imm = 0.
  - I: opa = val(ra), opb = 0, imm = zero-extended imm6.
  - J: opa = opb = 0, imm = zero-extended imm9.
  - 00: all zero.
- val(r) forwarding rule:
  - Use the lowest-index i with fwd_valid[i] and fwd_addr[i] == r, giving fwd_data[i].
  - Otherwise use rf_rdata.
  - The search is purely combinational.
- out_dst = rd for R, rb for I, 0 otherwise.
- Load-use hazard:
  - hazard = in_valid && ex_load_valid && (ra == ex_load_dst for R/I, or rb == ex_load_dst for R).
  - While hazard is high, in_ready = 0 and the output register loads a bubble (out_valid 0) whenever it would otherwise advance.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !hazard.
  - On an edge with in_valid && in_ready, the output register loads the new instruction and out_valid = 1.
  - On an edge with advance && !(in_valid && in_ready), out_valid = 0.
  - While out_valid && !out_ready, all out_* hold stable.
- Latency: 1 cycle from accept to out_valid; throughput is 1 instruction/cycle with no hazard.
- Flush:
  - On the next edge, out_valid = 0 and any instruction presented that cycle is dropped.
  - Flush overrides accept and hold.
  - in_ready may still be high during flush; the producer treats the instruction as consumed.
- Reset (resetn = 0 at an edge):
  - out_valid = 0 and every out_* data register = 0.
  - Takes priority over flush and any in-flight transfer.
  - in_ready is combinational from registered state, so it is 1 once out_valid = 0.
- Simultaneous forwarding hits: a lower index always wins; a hit on both ra and rb may come from different sources.
- fwd_addr matching needs no special case for r == 0; register 0 is an ordinary register.

Optional Feature:
- Macro RR_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_hazard_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_hazard_cnt increments on each cycle with hazard high.
  - perf_stall_cnt increments on each cycle with out_valid && !out_ready.
  - Both saturate at 32'hFFFF_FFFF, clear on reset, and are not cleared by flush.
- Undefined: the ports and logic are absent and all other behaviour is identical.

Decomposition:
- Package rr_pkg holds:
  - fmt localparams: FMT_R = 2'b11, FMT_I = 2'b10, FMT_J = 2'b01, FMT_NONE = 2'b00.
  - Field bit positions.
  - Immediate widths IMM_I_W = 6, IMM_J_W = 9.
- One sub-module rr_fwd_mux (parameters AW, DATA_W, NUM_FWD): priority-select forwarding mux, instantiated twice (operand A, operand B).

Test Plan:
- R instr, ra = 2 (RF = 16'h1234), rb = 5 (RF = 16'h00FF), rd = 3, out_ready = 1 → next cycle out_valid = 1, opa = 1234, opb = 00FF, dst = 3, imm = 0.
- I instr imm6 = 6'h2A, ra = 1 (RF = 7); fwd_valid = 2'b11 with both fwd_addr = 1, fwd_data[0] = AAAA, fwd_data[1] = BBBB → opa = AAAA, imm = 002A.
- J instr imm9 = 9'h1FF → opa = opb = 0, imm = 01FF, dst = 0.
- ex_load_valid = 1, ex_load_dst = 4, R instr with rb = 4 → in_ready = 0 and out_valid = 0 for that cycle; drop ex_load_valid → accepted next edge.
- Back-to-back 3 instrs with out_ready low for 2 cycles on the 2nd → out_* stable while stalled, in_ready = 0, no loss or duplication, order preserved.
- Flush asserted during a stall with out_valid = 1 → out_valid = 0 next edge. resetn = 0 mid-stream → all outputs 0; with RR_PERF_CNT_EN, the counters read 0 after reset and count exact stall/hazard cycles.
